lfsr_gen: RTL and testbench

Parametrised Fibonacci LFSR for pseudo-random sequence generation in the test-pattern and noise sources. It generalises the fixed 17-bit LFSR in four ways: width and tap polynomial are parameters, multiple bits advance per enable, the start state is runtime-loadable with all-zero protection, and a registered period counter with a wrap pulse tracks returns to the start state. Downstream consumers take the full state `q` or the newest `STEP` bits.

---
 rtl/lfsr_gen.sv | 86 ++++++++
 tb/tb_lfsr_gen.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_gen.sv
// Parametrised Fibonacci LFSR with multi-bit stepping, runtime-loadable start state,
// all-zero load protection and a period counter that pulses wrap on return to start.
module lfsr_gen #(
    parameter int              WIDTH = 17,
    parameter logic [WIDTH-1:0] TAPS = 17'h12000,
    parameter logic [WIDTH-1:0] SEED = 17'h0002B,
    parameter int              STEP  = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic [STEP-1:0]  bits_out,
    output logic [WIDTH-1:0] step_cnt,
    output logic             wrap,
    output logic             err
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] start_reg;
    logic [WIDTH-1:0] step_cnt_reg;
    logic             wrap_reg;
    logic             err_reg;
    logic [WIDTH-1:0] q_next;
    logic             hit_start;

    function automatic logic [WIDTH-1:0] shift1(input logic [WIDTH-1:0] s);
        return {s[WIDTH-2:0], ^(s & TAPS)};
    endfunction

    // STEP single-bit shifts unrolled into one combinational cycle; newest bit at index 0.
    always_comb begin
        q_next = q_reg;
        for (int i = 0; i < STEP; i++) begin
            q_next = shift1(q_next);
        end
    end

    assign hit_start = (q_next == start_reg);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_reg        <= SEED;
            start_reg    <= SEED;
            step_cnt_reg <= '0;
            wrap_reg     <= 1'b0;
            err_reg      <= 1'b0;
        end else if (load) begin
            // A zero load would lock the register; substitute SEED and flag it.
            if (load_val != '0) begin
                q_reg     <= load_val;
                start_reg <= load_val;
                err_reg   <= 1'b0;
            end else begin
                q_reg     <= SEED;
                start_reg <= SEED;
                err_reg   <= 1'b1;
            end
            step_cnt_reg <= '0;
            wrap_reg     <= 1'b0;
        end else if (en) begin
            q_reg    <= q_next;
            wrap_reg <= hit_start;
            err_reg  <= 1'b0;
            if (hit_start) begin
                step_cnt_reg <= '0;
            end else begin
                step_cnt_reg <= step_cnt_reg + ONE;
            end
        end else begin
            wrap_reg <= 1'b0;
            err_reg  <= 1'b0;
        end
    end

    assign q        = q_reg;
    assign bits_out = q_reg[STEP-1:0];
    assign step_cnt = step_cnt_reg;
    assign wrap     = wrap_reg;
    assign err      = err_reg;

endmodule

// File: tb/tb_lfsr_gen.sv
// Scoreboard bench for lfsr_gen: a 17-bit default instance plus two 8-bit instances
// (STEP=1 and STEP=4) whose short period allows full-period wrap checks.
module tb_lfsr_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, en, load;
    logic [16:0] load_val, q, step_cnt;
    logic        bits_out, wrap, err;

    logic        en8, load8;
    logic [7:0]  lv8, q8, cnt8, q4, cnt4;
    logic        b8, wrap8, err8, wrap4, err4;
    logic [3:0]  b4;

    lfsr_gen dut (
        .clk(clk), .rst_n(rst_n), .en(en), .load(load), .load_val(load_val),
        .q(q), .bits_out(bits_out), .step_cnt(step_cnt), .wrap(wrap), .err(err)
    );

    lfsr_gen #(.WIDTH(8), .TAPS(8'hB8), .SEED(8'h01), .STEP(1)) dut8 (
        .clk(clk), .rst_n(rst_n), .en(en8), .load(load8), .load_val(lv8),
        .q(q8), .bits_out(b8), .step_cnt(cnt8), .wrap(wrap8), .err(err8)
    );

    lfsr_gen #(.WIDTH(8), .TAPS(8'hB8), .SEED(8'h01), .STEP(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .en(en8), .load(load8), .load_val(lv8),
        .q(q4), .bits_out(b4), .step_cnt(cnt4), .wrap(wrap4), .err(err4)
    );

    typedef struct {
        logic [16:0] q;
        logic [16:0] cnt;
        logic        wrap;
        logic        err;
    } exp_t;

    exp_t sb[$];
    exp_t sb8[$];
    exp_t sb4[$];

    int total = 0;
    int bad   = 0;

    logic [16:0] mq, ms, mc;
    logic [7:0]  m8q, m8s, m8c, m4q, m4s, m4c;

    function automatic logic [16:0] f17(input logic [16:0] s);
        return {s[15:0], ^(s & 17'h12000)};
    endfunction

    function automatic logic [7:0] f8(input logic [7:0] s);
        return {s[6:0], ^(s & 8'hB8)};
    endfunction

    task automatic model_reset();
        mq = 17'h0002B; ms = 17'h0002B; mc = '0;
        m8q = 8'h01; m8s = 8'h01; m8c = '0;
        m4q = 8'h01; m4s = 8'h01; m4c = '0;
    endtask

    // Drive one cycle on the 17-bit instance and queue the expected result.
    task automatic drive17(input logic e, input logic l, input logic [16:0] v);
        exp_t x;
        logic [16:0] n;
        en = e; load = l; load_val = v;
        x.wrap = 1'b0; x.err = 1'b0;
        if (l) begin
            if (v != 17'h0) begin
                mq = v;
            end else begin
                mq = 17'h0002B;
                x.err = 1'b1;
            end
            ms = mq; mc = '0;
        end else if (e) begin
            n = f17(mq);
            if (n == ms) begin
                mc = '0; x.wrap = 1'b1;
            end else begin
                mc = mc + 17'd1;
            end
            mq = n;
        end
        x.q = mq; x.cnt = mc;
        sb.push_back(x);
        @(posedge clk); #1;
        $display("txn17 en=%b load=%b val=%h -> q=%h cnt=%0d wrap=%b err=%b",
                 e, l, v, q, step_cnt, wrap, err);
    endtask

    // Drive one enable cycle on both 8-bit instances.
    task automatic drive8(input logic e);
        exp_t x, y;
        logic [7:0] n;
        en8 = e;
        x.wrap = 1'b0; x.err = 1'b0; y.wrap = 1'b0; y.err = 1'b0;
        if (e) begin
            n = f8(m8q);
            if (n == m8s) begin m8c = '0; x.wrap = 1'b1; end
            else m8c = m8c + 8'd1;
            m8q = n;
            n = f8(f8(f8(f8(m4q))));
            if (n == m4s) begin m4c = '0; y.wrap = 1'b1; end
            else m4c = m4c + 8'd1;
            m4q = n;
        end
        x.q = {9'h0, m8q}; x.cnt = {9'h0, m8c};
        y.q = {9'h0, m4q}; y.cnt = {9'h0, m4c};
        sb8.push_back(x);
        sb4.push_back(y);
        @(posedge clk); #1;
        $display("txn8 en=%b -> q8=%h cnt8=%0d w8=%b | q4=%h cnt4=%0d w4=%b",
                 e, q8, cnt8, wrap8, q4, cnt4, wrap4);
    endtask

    task automatic test_reset();
        rst_n = 1'b1; en = 1'b0; load = 1'b0; load_val = '0;
        en8 = 1'b0; load8 = 1'b0; lv8 = '0;
        #1 rst_n = 1'b0;
        #2;
        model_reset();
        total++;
        if (q !== 17'h0002B || step_cnt !== 17'h0 || wrap !== 1'b0 || err !== 1'b0) begin
            bad++;
            $display("FAIL reset17 q=%h cnt=%0d w=%b e=%b want q=0002b cnt=0 w=0 e=0",
                     q, step_cnt, wrap, err);
        end
        total++;
        if (q8 !== 8'h01 || cnt8 !== 8'h0 || q4 !== 8'h01 || cnt4 !== 8'h0 || wrap8 !== 1'b0) begin
            bad++;
            $display("FAIL reset8 q8=%h cnt8=%0d q4=%h cnt4=%0d want 01/0/01/0", q8, cnt8, q4, cnt4);
        end
        #4 rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_stepping();
        exp_t x;
        logic [16:0] want [3] = '{17'h00056, 17'h000AC, 17'h00158};
        for (int i = 0; i < 3; i++) begin
            drive17(1'b1, 1'b0, 17'h0);
            x = sb.pop_front();
            total++;
            if (q !== x.q || step_cnt !== x.cnt || wrap !== x.wrap || err !== x.err) begin
                bad++;
                $display("FAIL step%0d got q=%h cnt=%0d w=%b e=%b want q=%h cnt=%0d w=%b e=%b",
                         i, q, step_cnt, wrap, err, x.q, x.cnt, x.wrap, x.err);
            end
            total++;
            if (q !== want[i] || step_cnt !== 17'(i + 1) || bits_out !== want[i][0]) begin
                bad++;
                $display("FAIL step_const%0d got q=%h cnt=%0d bit=%b want q=%h cnt=%0d bit=%b",
                         i, q, step_cnt, bits_out, want[i], i + 1, want[i][0]);
            end
        end
    endtask

    task automatic test_load();
        exp_t x;
        logic        e_t  [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
        logic        l_t  [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        logic [16:0] v_t  [4] = '{17'h1FFFF, 17'h0, 17'h0, 17'h0};
        logic [16:0] wq_t [4] = '{17'h1FFFF, 17'h1FFFE, 17'h0002B, 17'h0002B};
        logic        we_t [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 4; i++) begin
            drive17(e_t[i], l_t[i], v_t[i]);
            x = sb.pop_front();
            total++;
            if (q !== x.q || step_cnt !== x.cnt || wrap !== x.wrap || err !== x.err) begin
                bad++;
                $display("FAIL load%0d got q=%h cnt=%0d w=%b e=%b want q=%h cnt=%0d w=%b e=%b",
                         i, q, step_cnt, wrap, err, x.q, x.cnt, x.wrap, x.err);
            end
            total++;
            if (q !== wq_t[i] || err !== we_t[i]) begin
                bad++;
                $display("FAIL load_const%0d got q=%h e=%b want q=%h e=%b",
                         i, q, err, wq_t[i], we_t[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        exp_t x;
        logic        e_t [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        logic        l_t [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        logic [16:0] v_t [6] = '{17'h0, 17'h0, 17'h00001, 17'h0, 17'h0, 17'h0};
        for (int i = 0; i < 6; i++) begin
            drive17(e_t[i], l_t[i], v_t[i]);
            x = sb.pop_front();
            total++;
            if (q !== x.q || step_cnt !== x.cnt || wrap !== x.wrap || err !== x.err) begin
                bad++;
                $display("FAIL b2b%0d got q=%h cnt=%0d w=%b e=%b want q=%h cnt=%0d w=%b e=%b",
                         i, q, step_cnt, wrap, err, x.q, x.cnt, x.wrap, x.err);
            end
        end
        total++;
        if (q !== 17'h00002 || step_cnt !== 17'd1) begin
            bad++;
            $display("FAIL b2b_hold got q=%h cnt=%0d want q=00002 cnt=1", q, step_cnt);
        end
    endtask

    task automatic test_full_period();
        exp_t x, y;
        int last8 = 0, last4 = 0, wraps8 = 0, wraps4 = 0;
        logic [7:0] prev_cnt8 = '0;
        for (int c = 1; c <= 520; c++) begin
            drive8(1'b1);
            x = sb8.pop_front();
            y = sb4.pop_front();
            total++;
            if (q8 !== x.q[7:0] || cnt8 !== x.cnt[7:0] || wrap8 !== x.wrap || err8 !== 1'b0 ||
                b8 !== x.q[0]) begin
                bad++;
                $display("FAIL period8 c=%0d got q=%h cnt=%0d w=%b want q=%h cnt=%0d w=%b",
                         c, q8, cnt8, wrap8, x.q[7:0], x.cnt[7:0], x.wrap);
            end
            total++;
            if (q4 !== y.q[7:0] || cnt4 !== y.cnt[7:0] || wrap4 !== y.wrap || q4 === 8'h00 ||
                b4 !== y.q[3:0]) begin
                bad++;
                $display("FAIL step4 c=%0d got q=%h cnt=%0d w=%b want q=%h cnt=%0d w=%b",
                         c, q4, cnt4, wrap4, y.q[7:0], y.cnt[7:0], y.wrap);
            end
            if (c == 1) begin
                total++;
                if (q4 !== 8'h11 || q8 !== 8'h02) begin
                    bad++;
                    $display("FAIL first_step got q4=%h q8=%h want q4=11 q8=02", q4, q8);
                end
            end
            if (wrap8 === 1'b1) begin
                wraps8++;
                total++;
                if (c - last8 != 255 || q8 !== 8'h01 || cnt8 !== 8'h0 || prev_cnt8 !== 8'd254) begin
                    bad++;
                    $display("FAIL wrap8 c=%0d gap=%0d q=%h prev_cnt=%0d want gap=255 q=01 prev_cnt=254",
                             c, c - last8, q8, prev_cnt8);
                end
                last8 = c;
            end
            if (wrap4 === 1'b1) begin
                wraps4++;
                total++;
                if (c - last4 != 255 || q4 !== 8'h01 || cnt4 !== 8'h0) begin
                    bad++;
                    $display("FAIL wrap4 c=%0d gap=%0d q=%h want gap=255 q=01", c, c - last4, q4);
                end
                last4 = c;
            end
            prev_cnt8 = cnt8;
        end
        en8 = 1'b0;
        total++;
        if (wraps8 != 2 || wraps4 != 2) begin
            bad++;
            $display("FAIL wrap_count got w8=%0d w4=%0d want 2 and 2", wraps8, wraps4);
        end
    endtask

    task automatic test_async_reset();
        exp_t x;
        for (int run = 0; run < 2; run++) begin
            en = 1'b1; load = 1'b0;
            #2 rst_n = 1'b0;
            #1;
            model_reset();
            total++;
            if (q !== 17'h0002B || step_cnt !== 17'h0 || wrap !== 1'b0 || err !== 1'b0 ||
                q8 !== 8'h01) begin
                bad++;
                $display("FAIL async_rst%0d got q=%h cnt=%0d w=%b e=%b q8=%h want 0002b/0/0/0/01",
                         run, q, step_cnt, wrap, err, q8);
            end
            en = 1'b0;
            rst_n = 1'b1;
            @(posedge clk); #1;
            for (int i = 0; i < 100; i++) begin
                drive17(1'b1, 1'b0, 17'h0);
                x = sb.pop_front();
                total++;
                if (q !== x.q || step_cnt !== x.cnt || wrap !== x.wrap || err !== x.err) begin
                    bad++;
                    $display("FAIL rerun%0d_%0d got q=%h cnt=%0d want q=%h cnt=%0d",
                             run, i, q, step_cnt, x.q, x.cnt);
                end
                if (i == 0) begin
                    total++;
                    if (q !== 17'h00056) begin
                        bad++;
                        $display("FAIL rerun%0d_first got q=%h want 00056", run, q);
                    end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_stepping();
        test_load();
        test_back_to_back();
        test_full_period();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
